// File: rtl/ram_responder.sv
// Latency-configurable single-port word RAM slave with FREE/BUSY/ACCESS handshake.
// Optional RAM_ERROR_EN reports conflicting or out-of-range requests as ERROR.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

import cpu_types_pkg::*;

module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_BUSY = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_wr;
  logic        r_err;
  logic        w_req;
  logic        w_abort;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] r_mem [2**AW];

  assign w_req = ramREN | ramWEN;
  assign w_idx = r_addr[AW+1:2];

  // Initiator must hold op and address steady while we count down.
  assign w_abort = !w_req
                || (ramWEN != r_wr)
                || (ramaddr != r_addr);

`ifdef RAM_ERROR_EN
  assign w_err = (ramREN & ramWEN)
              || (ramaddr[31:2] >= 30'(DEPTH));
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FREE: begin
        if (w_req) begin
          if (w_err || LAT == 0) w_next = S_ACC;
          else                   w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_abort)            w_next = S_FREE;
        else if (r_cnt == 4'd1) w_next = S_ACC;
      end
      S_ACC:   w_next = S_FREE;
      default: w_next = S_FREE;
    endcase
  end

  always_comb begin
    ramstate = FREE;
    ramload  = '0;
    unique case (r_state)
      S_BUSY: ramstate = BUSY;
      S_ACC: begin
        ramstate = r_err ? ERROR : ACCESS;
        if (!r_wr && !r_err) ramload = r_mem[w_idx];
      end
      default: ramstate = FREE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_FREE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_FREE: begin
          if (w_req) begin
            r_addr <= ramaddr;
            r_wr   <= ramWEN;
            r_err  <= w_err;
            r_cnt  <= 4'(LAT);
          end
        end
        S_BUSY: begin
          if (w_abort) r_cnt <= '0;
          else         r_cnt <= r_cnt - 4'd1;
        end
        S_ACC: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (r_state == S_ACC && r_wr && !r_err)
      r_mem[w_idx] <= ramstore;
  end

endmodule
